reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 81 ++++++++
 tb/tb_reg_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register saturating pending-write counters that
// hold issue on RAW hazards or a full counter, and track total outstanding writes.
module reg_scoreboard #(
  parameter int unsigned WORD_COUNT  = 32,
  parameter int unsigned MAX_PENDING = 3,
  localparam int unsigned IDX_W = $clog2(WORD_COUNT),
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1),
  localparam int unsigned OUT_W = $clog2(WORD_COUNT * MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issueValid,
  input  logic             issueWrites,
  input  logic [IDX_W-1:0] issueDst,
  input  logic [IDX_W-1:0] rs,
  input  logic [IDX_W-1:0] rt,
  input  logic             wbValid,
  input  logic [IDX_W-1:0] wbDst,
  input  logic             flush,
  output logic             stall,
  output logic             rsBusy,
  output logic             rtBusy,
  output logic [OUT_W-1:0] outstanding,
  output logic             wbError
);

  logic [CNT_W-1:0]      pend [WORD_COUNT];
  logic                  dst_full;
  logic                  accept;
  logic                  inc;
  logic                  dec;
  logic                  wb_err;
  logic [WORD_COUNT-1:0] inc_sel;
  logic [WORD_COUNT-1:0] dec_sel;

  always_comb begin
    rsBusy   = (rs != '0) && (pend[rs] != '0);
    rtBusy   = (rt != '0) && (pend[rt] != '0);
    dst_full = issueWrites && (issueDst != '0) && (pend[issueDst] == CNT_W'(MAX_PENDING));
    stall    = issueValid && (rsBusy || rtBusy || dst_full);
    accept   = issueValid && !stall && !flush;
    inc      = accept && issueWrites && (issueDst != '0);
    dec      = wbValid && (wbDst != '0) && (pend[wbDst] != '0);
    wb_err   = wbValid && (wbDst != '0) && (pend[wbDst] == '0);
  end

  always_comb begin
    inc_sel = '0;
    dec_sel = '0;
    for (int unsigned r = 1; r < WORD_COUNT; r++) begin
      inc_sel[r] = inc && (issueDst == IDX_W'(r));
      dec_sel[r] = dec && (wbDst == IDX_W'(r));
    end
  end

  // Counters see only pre-edge values; an issue and a writeback hitting the
  // same register cancel, and outstanding follows the same net +1/-1/0 rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < WORD_COUNT; r++) pend[r] <= '0;
      outstanding <= '0;
      wbError     <= 1'b0;
    end else if (flush) begin
      for (int unsigned r = 0; r < WORD_COUNT; r++) pend[r] <= '0;
      outstanding <= '0;
    end else begin
      if (wb_err) wbError <= 1'b1;
      for (int unsigned r = 1; r < WORD_COUNT; r++) begin
        if (inc_sel[r] && !dec_sel[r])
          pend[r] <= pend[r] + CNT_W'(1);
        else if (dec_sel[r] && !inc_sel[r])
          pend[r] <= pend[r] - CNT_W'(1);
      end
      if (inc && !dec)
        outstanding <= outstanding + OUT_W'(1);
      else if (dec && !inc)
        outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked against an array-based model.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issueValid, issueWrites, wbValid, flush;
  logic [4:0] issueDst, rs, rt, wbDst;
  logic       stall, rsBusy, rtBusy, wbError;
  logic [6:0] outstanding;

  int total = 0;
  int bad   = 0;
  int pend_m [32];
  int err_m;

  reg_scoreboard #(.WORD_COUNT(32), .MAX_PENDING(3)) dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueWrites(issueWrites), .issueDst(issueDst),
    .rs(rs), .rt(rt), .wbValid(wbValid), .wbDst(wbDst), .flush(flush),
    .stall(stall), .rsBusy(rsBusy), .rtBusy(rtBusy),
    .outstanding(outstanding), .wbError(wbError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (pend_m[r] != 0);
  endfunction

  function automatic bit m_stall();
    bit full;
    full = issueWrites && (issueDst != 0) && (pend_m[issueDst] == 3);
    return issueValid && (m_busy(int'(rs)) || m_busy(int'(rt)) || full);
  endfunction

  function automatic int m_out();
    int s = 0;
    foreach (pend_m[i]) s += pend_m[i];
    return s;
  endfunction

  task automatic m_reset();
    foreach (pend_m[i]) pend_m[i] = 0;
    err_m = 0;
  endtask

  // Drive one cycle's inputs and compare every output against the model.
  task automatic present(input bit iv, input bit iw, input int d, input int a, input int b,
                         input bit wv, input int wd, input bit fl);
    issueValid = iv; issueWrites = iw; issueDst = 5'(d);
    rs = 5'(a); rt = 5'(b); wbValid = wv; wbDst = 5'(wd); flush = fl;
    #1;
    chk("stall", stall, m_stall());
    chk("rsBusy", rsBusy, m_busy(int'(rs)));
    chk("rtBusy", rtBusy, m_busy(int'(rt)));
    chk("outstanding", outstanding, m_out());
    chk("wbError", wbError, err_m);
  endtask

  task automatic idle();
    present(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit st;
    st = m_stall();
    @(posedge clk);
    if (flush) begin
      foreach (pend_m[i]) pend_m[i] = 0;
    end else begin
      if (wbValid && wbDst != 0 && pend_m[wbDst] == 0) err_m = 1;
      if (wbValid && wbDst != 0 && pend_m[wbDst] > 0) pend_m[wbDst]--;
      if (issueValid && !st && issueWrites && issueDst != 0) pend_m[issueDst]++;
    end
    @(negedge clk);
  endtask

  task automatic issue(input int d);
    present(1, 1, d, 0, 0, 0, 0, 0);
    tick();
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic async_rst();
    issueValid = 1; issueWrites = 0; wbValid = 0; flush = 0; rs = 5'd13; rt = 5'd0;
    #1 rst = 1'b1;
    #1;
    m_reset();
    chk("async_out", outstanding, 0);
    chk("async_wbError", wbError, 0);
    chk("async_rsBusy", rsBusy, 0);
    chk("async_stall", stall, 0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    issueValid = 0; issueWrites = 0; issueDst = '0; rs = '0; rt = '0;
    wbValid = 0; wbDst = '0; flush = 0;
    m_reset();
    #1;
    chk("reset_out", outstanding, 0);
    chk("reset_wbError", wbError, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Busy, stall and release through writeback.
    present(1, 1, 5, 0, 0, 0, 0, 0);
    chk("r30_first_stall", stall, 0);
    tick();
    present(1, 0, 0, 5, 0, 0, 0, 0);
    chk("r30_rsBusy", rsBusy, 1);
    chk("r30_stall", stall, 1);
    chk("r30_out", outstanding, 1);
    tick();
    present(0, 0, 0, 0, 0, 1, 5, 0);
    tick();
    present(1, 0, 0, 5, 0, 0, 0, 0);
    chk("r30_rsBusy_clr", rsBusy, 0);
    chk("r30_stall_clr", stall, 0);
    chk("r30_out_clr", outstanding, 0);
    tick();

    // Saturation at MAX_PENDING, released by one writeback.
    issue(7); issue(7); issue(7);
    present(1, 1, 7, 0, 0, 0, 0, 0);
    chk("r31_sat_stall", stall, 1);
    chk("r31_out", outstanding, 3);
    tick();
    present(1, 1, 7, 0, 0, 1, 7, 0);
    chk("r31_nobypass_stall", stall, 1);
    tick();
    present(1, 1, 7, 0, 0, 0, 0, 0);
    chk("r31_accept", stall, 0);
    tick();
    idle();
    chk("r31_out_after", outstanding, 3);
    present(0, 0, 0, 0, 0, 0, 0, 1);
    tick();

    // Same-cycle issue and writeback to one register.
    issue(9);
    present(1, 1, 9, 0, 0, 1, 9, 0);
    chk("r32_accept", stall, 0);
    tick();
    idle();
    chk("r32_out_same", outstanding, 1);
    present(1, 1, 9, 9, 0, 1, 9, 0);
    chk("r32_stall", stall, 1);
    chk("r32_rsBusy", rsBusy, 1);
    tick();
    idle();
    chk("r32_out_drain", outstanding, 0);
    tick();

    // Writeback errors and register 0.
    present(0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    idle();
    chk("r33_wb0_noerr", wbError, 0);
    present(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    chk("r33_dst0_out", outstanding, 0);
    present(0, 0, 0, 0, 0, 1, 12, 0);
    tick();
    idle();
    chk("r33_wbError", wbError, 1);
    chk("r33_out", outstanding, 0);
    tick();

    // Asynchronous reset with state present.
    issue(1); issue(2); issue(3); issue(4);
    idle();
    chk("r35_out_pre", outstanding, 4);
    chk("r35_err_pre", wbError, 1);
    async_rst();

    // Flush beats a simultaneous issue.
    issue(3); issue(3); issue(4); issue(4);
    idle();
    chk("r34_out_pre", outstanding, 4);
    present(1, 1, 3, 0, 0, 0, 0, 1);
    tick();
    present(1, 0, 0, 3, 4, 0, 0, 0);
    chk("r34_rsBusy", rsBusy, 0);
    chk("r34_rtBusy", rtBusy, 0);
    chk("r34_out", outstanding, 0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit iv, iw, wv, fl;
      int d, a, b, wd;
      iv = ($urandom_range(0, 9) < 7);
      iw = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
      b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0;
      fl = ($urandom_range(0, 99) < 3);
      wv = !fl && ($urandom_range(0, 1) == 1);
      wd = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (wd + k) % 8;
          if (pend_m[c] != 0) begin
            wd = c;
            break;
          end
        end
      end
      if (wv && pend_m[wd] == 0 && wd == d) wd = 0;
      present(iv, iw, d, a, b, wv, wd, fl);
      tick();
      if (n % 500 == 499) async_rst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
